// File: rtl/vga_framebuffer.sv
// Double-buffered packed-pixel framebuffer with a 16-entry palette. CPU stores land in the
// back bank, and scan-out reads palette-resolved RGB from the front bank through a 2-stage pipe.
package vga_framebuffer_pkg;
  typedef struct packed {
    logic       memWrite;
    logic [1:0] size;
  } mem_ctrl_t;
endpackage

// One byte lane of a store: works out whether this lane's byte lands inside the pixel RAM.
module vga_fb_wlane #(
  parameter int LANE     = 0,
  parameter int FB_BYTES = 1,
  parameter int AW       = 1
) (
  input  logic          we,
  input  logic [31:0]   base,
  input  logic [2:0]    nbytes,
  output logic          en,
  output logic [AW-1:0] idx
);
  logic [31:0] a;

  assign a   = base + 32'(LANE);
  assign en  = we && (32'(LANE) < 32'(nbytes)) && (a < 32'(FB_BYTES));
  assign idx = a[AW-1:0];
endmodule

module vga_framebuffer
  import vga_framebuffer_pkg::*;
#(
  parameter int          H_PIX    = 160,
  parameter int          V_PIX    = 120,
  parameter int          BPP      = 4,
  parameter logic [31:0] PAL_BASE = 32'h0001_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_wdata,
  input  mem_ctrl_t                i_ctrl,
  input  logic                     i_rd_en,
  input  logic [$clog2(H_PIX)-1:0] i_pxlX,
  input  logic [$clog2(V_PIX)-1:0] i_pxlY,
  input  logic                     i_frame_start,
  input  logic                     i_swap_req,
  output logic [11:0]              o_pixel,
  output logic                     o_valid,
  output logic                     o_front,
  output logic                     o_swap_pending
);
  localparam int ROW_BYTES = H_PIX * BPP / 8;
  localparam int FB_BYTES  = V_PIX * ROW_BYTES;
  localparam int PPB       = 8 / BPP;
  localparam int PSH       = $clog2(PPB);
  localparam int AW        = $clog2(FB_BYTES);
  localparam int NUM_LANES = 4;
  localparam int STAGES    = 2;
  localparam int PIX_MASK  = (1 << BPP) - 1;

  generate
    if (!(BPP == 1 || BPP == 2 || BPP == 4)) begin : g_bad_bpp
      $error("vga_framebuffer: BPP must be 1, 2 or 4");
    end
  endgenerate

  logic [7:0]  mem [2][FB_BYTES];
  logic [11:0] pal [16];

  // ---------------- store path ----------------
  logic [31:0] wr_base;
  logic [2:0]  wr_n;
  logic        wr_bank;
  logic        pal_we;

  logic [NUM_LANES-1:0]         lane_en;
  logic [NUM_LANES-1:0][AW-1:0] lane_idx;
  logic [NUM_LANES-1:0][7:0]    lane_data;

  always_comb begin
    wr_base = i_addr;
    wr_n    = 3'd0;
    case (i_ctrl.size)
      2'b00:   begin wr_base = i_addr;                wr_n = 3'd1; end
      2'b01:   begin wr_base = {i_addr[31:1], 1'b0};  wr_n = 3'd2; end
      2'b10:   begin wr_base = {i_addr[31:2], 2'b00}; wr_n = 3'd4; end
      default: begin wr_base = i_addr;                wr_n = 3'd0; end
    endcase
  end

  // The back bank is whatever o_front is not at this edge, so a store coincident with a
  // swap still lands in the bank that is about to become visible.
  assign wr_bank = ~o_front;
  assign pal_we  = i_ctrl.memWrite && (i_ctrl.size == 2'b10) &&
                   (i_addr >= PAL_BASE) && (i_addr < PAL_BASE + 32'd64);

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      vga_fb_wlane #(.LANE(k), .FB_BYTES(FB_BYTES), .AW(AW)) u_wlane (
        .we     (i_ctrl.memWrite),
        .base   (wr_base),
        .nbytes (wr_n),
        .en     (lane_en[k]),
        .idx    (lane_idx[k])
      );
      assign lane_data[k] = i_wdata[8*k +: 8];
    end
  endgenerate

  // ---------------- read stage 1 ----------------
  logic          rd_in;
  logic [AW-1:0] rd_idx;
  logic          s1_in;
  logic [PSH-1:0] s1_xl;
  logic [7:0]    s1_byte;

  assign rd_in  = (32'(i_pxlX) < H_PIX) && (32'(i_pxlY) < V_PIX);
  assign rd_idx = rd_in ? AW'(i_pxlY) * AW'(ROW_BYTES) + AW'(i_pxlX >> PSH) : '0;

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_LANES; k++)
      if (lane_en[k]) mem[wr_bank][lane_idx[k]] <= lane_data[k];
    s1_byte <= mem[o_front][rd_idx];
    s1_in   <= rd_in;
    s1_xl   <= i_pxlX[PSH-1:0];
  end

  // ---------------- read stage 2 ----------------
  logic [STAGES:1] vld_pipe;
  logic [3:0]      px_idx;

  assign px_idx  = 4'((s1_byte >> (32'(s1_xl) * BPP)) & 8'(PIX_MASK));
  assign o_valid = vld_pipe[STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe <= '0;
      o_pixel  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], i_rd_en};
      if (vld_pipe[1]) o_pixel <= s1_in ? pal[px_idx] : 12'h000;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
    end else if (pal_we) begin
      pal[i_addr[5:2]] <= i_wdata[11:0];
    end
  end

  // ---------------- swap control ----------------
  typedef enum logic {IDLE, PENDING} swap_state_t;
  swap_state_t state, state_nxt;
  logic        toggle;

  always_comb begin
    state_nxt = state;
    toggle    = 1'b0;
    if (i_swap_req && i_frame_start) begin
      toggle    = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_swap_req) state_nxt = PENDING;
        PENDING: if (i_frame_start) begin
                   toggle    = 1'b1;
                   state_nxt = IDLE;
                 end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      o_front <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_front <= o_front ^ toggle;
    end
  end

  assign o_swap_pending = (state == PENDING);
endmodule
